// File: rtl/hc595_rx.sv
// Receiver for the 3-wire 74HC595-style display link: oversamples SH_CP/ST_CP/DS and rebuilds latched frames.
// Optional digit decode outputs are enabled by defining HC595_RX_DIGIT_DECODE_EN.
module hc595_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sh_cp_i,
  input  logic                       st_cp_i,
  input  logic                       ds_i,
  input  logic                       err_clr_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(WIDTH)+1:0]   bit_cnt_o,
`ifdef HC595_RX_DIGIT_DECODE_EN
  output logic                       frame_err_o,
  output logic [2:0]                 digit_idx_o,
  output logic [3:0]                 digit_val_o,
  output logic                       digit_ok_o
`else
  output logic                       frame_err_o
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 2;

  logic [SYNC_STAGES-1:0] sh_sync;
  logic [SYNC_STAGES-1:0] st_sync;
  logic [SYNC_STAGES-1:0] ds_sync;
  logic                   sh_hist;
  logic                   st_hist;
  logic [WIDTH-1:0]       shreg;
  logic [WIDTH-1:0]       shift_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   sh_s;
  logic                   st_s;
  logic                   ds_s;
  logic                   shift_ev;
  logic                   latch_ev;

  assign sh_s      = sh_sync[SYNC_STAGES-1];
  assign st_s      = st_sync[SYNC_STAGES-1];
  assign ds_s      = ds_sync[SYNC_STAGES-1];
  assign shift_ev  = sh_s & ~sh_hist;
  assign latch_ev  = st_s & ~st_hist;
  assign bit_cnt_o = bit_cnt;

  // Next shift-register contents for the configured bit order
  always_comb begin
    shift_nxt = shreg;
    if (MSB_FIRST) begin
      shift_nxt = {shreg[WIDTH-2:0], ds_s};
    end else begin
      shift_nxt = {ds_s, shreg[WIDTH-1:1]};
    end
  end

  // Synchronisers, edge history, shift register, storage and error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_sync     <= '0;
      st_sync     <= '0;
      ds_sync     <= '0;
      sh_hist     <= 1'b0;
      st_hist     <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sh_sync <= {sh_sync[SYNC_STAGES-2:0], sh_cp_i};
      st_sync <= {st_sync[SYNC_STAGES-2:0], st_cp_i};
      ds_sync <= {ds_sync[SYNC_STAGES-2:0], ds_i};
      sh_hist <= sh_s;
      st_hist <= st_s;
      valid_o <= latch_ev;

      if (shift_ev) begin
        shreg <= shift_nxt;
      end

      // Storage sees pre-shift contents when both edges coincide
      if (latch_ev) begin
        data_o  <= shreg;
        bit_cnt <= shift_ev ? CNT_W'(1) : '0;
      end else if (shift_ev && (bit_cnt != {CNT_W{1'b1}})) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (latch_ev && (bit_cnt != CNT_W'(WIDTH))) begin
        frame_err_o <= 1'b1;
      end else if (err_clr_i) begin
        frame_err_o <= 1'b0;
      end
    end
  end

`ifdef HC595_RX_DIGIT_DECODE_EN
  logic [7:0] sel_byte;
  logic [7:0] seg_byte;
  logic [2:0] idx_c;
  logic [3:0] val_c;
  logic       seg_ok_c;
  logic       sel_ok_c;

  assign sel_byte = data_o[7:0];
  assign seg_byte = data_o[15:8];

  // Active-low common-anode segment code to digit value, one-hot select to index
  always_comb begin
    idx_c    = 3'd0;
    val_c    = 4'hF;
    seg_ok_c = 1'b1;
    sel_ok_c = $onehot(sel_byte);
    for (int i = 0; i < 8; i++) begin
      if (sel_byte[i]) begin
        idx_c = 3'(i);
      end
    end
    case (seg_byte)
      8'hC0:   val_c = 4'd0;
      8'hF9:   val_c = 4'd1;
      8'hA4:   val_c = 4'd2;
      8'hB0:   val_c = 4'd3;
      8'h99:   val_c = 4'd4;
      8'h92:   val_c = 4'd5;
      8'h82:   val_c = 4'd6;
      8'hF8:   val_c = 4'd7;
      8'h80:   val_c = 4'd8;
      8'h90:   val_c = 4'd9;
      default: seg_ok_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_idx_o <= 3'd0;
      digit_val_o <= 4'd0;
      digit_ok_o  <= 1'b0;
    end else if (valid_o) begin
      if (sel_ok_c && seg_ok_c) begin
        digit_idx_o <= idx_c;
        digit_val_o <= val_c;
        digit_ok_o  <= 1'b1;
      end else begin
        digit_idx_o <= 3'd0;
        digit_val_o <= 4'hF;
        digit_ok_o  <= 1'b0;
      end
    end
  end
`endif

endmodule
